// File: rtl/ro_freq_meter_wb.sv
// rtl/ro_freq_meter_wb.sv - Wishbone ring-oscillator frequency meter
// Counts synchronized ro_in rising edges over a programmable gate window of wb_clk_i cycles.
module ro_freq_meter_wb #(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int          CNT_W      = 24,
  parameter int          GATE_W     = 24,
  parameter int          SETTLE_CYC = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        ro_in,
  output logic [3:0]  ro_sel,
  output logic [4:0]  ro_en,
  output logic        ro_start
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t             state_q, state_d;
  logic [GATE_W-1:0]  gate_q, gate_d, gate_cnt;
  logic [CNT_W-1:0]   edge_cnt, count_q;
  logic [SET_W-1:0]   settle_cnt;
  logic [2:0]         ro_sync;
  logic               ro_edge;
  logic               done_q, ovf_q, ovf_pend;
  logic               busy;
  logic [31:0]        rdata;

  logic       hit, wr_en, ctrl_wr, stat_wr, go_req, abort_req;
  logic [1:0] reg_sel;
  logic       unused_bits;

  assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  // Writes commit at the end of the ack cycle, while the master still holds the bus.
  assign wr_en     = hit & wbs_ack_o & wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign ctrl_wr   = wr_en & (reg_sel == 2'd0);
  assign stat_wr   = wr_en & (reg_sel == 2'd3) & wbs_sel_i[0];
  assign go_req    = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[0];
  assign abort_req = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[2];
  assign busy      = (state_q != IDLE);
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

  // Bus side: single-cycle ack, registered read data, zero outside ack
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= hit & ~wbs_ack_o;
      wbs_dat_o <= (hit & ~wbs_ack_o & ~wbs_we_i) ? rdata : '0;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: begin
        rdata[1]     = ro_start;
        rdata[8:4]   = ro_en;
        rdata[15:12] = ro_sel;
      end
      2'd1: rdata[GATE_W-1:0] = gate_q;
      2'd2: rdata[CNT_W-1:0]  = count_q;
      default: rdata[2:0] = {ovf_q, done_q, busy};
    endcase
  end

  always_comb begin
    gate_d = gate_q;
    if (wr_en && reg_sel == 2'd1)
      for (int i = 0; i < GATE_W; i++)
        if (wbs_sel_i[i/8]) gate_d[i] = wbs_dat_i[i];
  end

  // Control outputs are frozen while a measurement is in flight
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ro_sel   <= '0;
      ro_en    <= '0;
      ro_start <= 1'b0;
      gate_q   <= GATE_W'(1000);
    end else begin
      gate_q <= gate_d;
      if (ctrl_wr && !busy) begin
        if (wbs_sel_i[0]) begin
          ro_start   <= wbs_dat_i[1];
          ro_en[3:0] <= wbs_dat_i[7:4];
        end
        if (wbs_sel_i[1]) begin
          ro_en[4] <= wbs_dat_i[8];
          ro_sel   <= wbs_dat_i[15:12];
        end
      end
    end
  end

  // Two-flop synchronizer plus registered rising-edge detect
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ro_sync <= '0;
      ro_edge <= 1'b0;
    end else begin
      ro_sync <= {ro_sync[1:0], ro_in};
      ro_edge <= ro_sync[1] & ~ro_sync[2];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_req && !abort_req) state_d = SETTLE;
      SETTLE: begin
        if (abort_req)
          state_d = IDLE;
        else if (settle_cnt == SET_W'(SETTLE_CYC - 1))
          state_d = (gate_cnt == '0) ? DONE : MEASURE;
      end
      MEASURE: begin
        if (abort_req)                       state_d = IDLE;
        else if (gate_cnt == GATE_W'(1))     state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      settle_cnt <= '0;
      ovf_pend   <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (stat_wr) begin
        if (wbs_dat_i[1]) done_q <= 1'b0;
        if (wbs_dat_i[2]) ovf_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (go_req && !abort_req) begin
            gate_cnt   <= gate_q;
            edge_cnt   <= '0;
            settle_cnt <= '0;
            ovf_pend   <= 1'b0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + 1'b1;
        MEASURE: begin
          gate_cnt <= gate_cnt - 1'b1;
          if (ro_edge) begin
            if (edge_cnt == {CNT_W{1'b1}}) ovf_pend <= 1'b1;
            else                            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        default: begin
          // Setting done/ovf here overrides a same-cycle W1C
          count_q <= edge_cnt;
          done_q  <= 1'b1;
          if (ovf_pend) ovf_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_meter_wb.sv
// tb/tb_ro_freq_meter_wb.sv - directed self-checking bench for ro_freq_meter_wb
// Two instances share the bus: default widths at A_BASE, CNT_W=8 at B_BASE.
module tb_ro_freq_meter_wb;

  localparam logic [31:0] A_BASE = 32'h3000_0000;
  localparam logic [31:0] B_BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ro_in = 1'b0;

  logic        ack_a, ack_b, ack;
  logic [31:0] dat_a, dat_b, rdat;
  logic [3:0]  ro_sel_a, ro_sel_b;
  logic [4:0]  ro_en_a, ro_en_b;
  logic        ro_start_a, ro_start_b;

  int checks = 0;
  int failures = 0;
  int cyc_count = 0;
  int last_ack_edge = 0;
  int ro_half = 50;

  assign ack  = ack_a | ack_b;
  assign rdat = dat_a | dat_b;

  ro_freq_meter_wb #(.BASE_ADR(A_BASE)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
    .ro_in(ro_in), .ro_sel(ro_sel_a), .ro_en(ro_en_a), .ro_start(ro_start_a)
  );

  ro_freq_meter_wb #(.BASE_ADR(B_BASE), .CNT_W(8)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
    .ro_in(ro_in), .ro_sel(ro_sel_b), .ro_en(ro_en_b), .ro_start(ro_start_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  initial begin
    #3;
    forever begin
      #(ro_half);
      ro_in = ~ro_in;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert (obs >= 32'(lo) && obs <= 32'(hi)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output int acks);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acks = 0; rd = '0; n = 0;
    while (!ack && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (ack) begin
      rd = rdat;
      last_ack_edge = cyc_count;
      acks = 1;
      @(negedge clk);
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int acks;
    bus(a, 1'b1, d, s, rd, acks);
    chk({tag, "_ack"}, 32'(acks), 32'd1);
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] a, output logic [31:0] rd);
    int acks;
    bus(a, 1'b0, '0, 4'hF, rd, acks);
    chk({tag, "_ack"}, 32'(acks), 32'd1);
  endtask

  task automatic wait_ack_at(input int target);
    while (cyc_count < target - 1) @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    int e0;

    // Asynchronous reset between clock edges
    #12 rst = 1'b1;
    #1;
    chk("rst_ack", {31'd0, ack_a}, 32'd0);
    chk("rst_dat", dat_a, 32'd0);
    chk("rst_outs", {22'd0, ro_sel_a, ro_en_a, ro_start_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_reg("gate_rst", A_BASE + 32'h4, v);   chk("gate_rst", v, 32'd1000);
    rd_reg("stat_rst", A_BASE + 32'hC, v);   chk("stat_rst", v, 32'd0);
    rd_reg("count_rst", A_BASE + 32'h8, v);  chk("count_rst", v, 32'd0);

    // CTRL field writes and byte lanes
    wr("ctrl1", A_BASE, 32'h0000_A1F2, 4'b0011);
    chk("ro_sel1", {28'd0, ro_sel_a}, 32'hA);
    chk("ro_en1", {27'd0, ro_en_a}, 32'h1F);
    chk("ro_start1", {31'd0, ro_start_a}, 32'd1);
    rd_reg("ctrl_rd", A_BASE, v);            chk("ctrl_rd", v, 32'h0000_A1F2);
    wr("ctrl2", A_BASE, 32'h0, 4'b0001);
    chk("ro_start2", {31'd0, ro_start_a}, 32'd0);
    chk("ro_sel2", {28'd0, ro_sel_a}, 32'hA);
    chk("ro_en2", {27'd0, ro_en_a}, 32'h10);

    // Zero-length gate window
    wr("gate0", A_BASE + 32'h4, 32'd0, 4'hF);
    wr("go0", A_BASE, 32'h1, 4'b0001);
    e0 = last_ack_edge;
    wait_ack_at(e0 + 18);
    rd_reg("g0_busy", A_BASE + 32'hC, v);    chk("g0_busy", v, 32'b001);
    wait_ack_at(e0 + 20);
    rd_reg("g0_done", A_BASE + 32'hC, v);    chk("g0_done", v, 32'b010);
    rd_reg("g0_cnt", A_BASE + 32'h8, v);     chk("g0_cnt", v, 32'd0);

    // Period 10 clocks, 1000-cycle window
    wr("clr1", A_BASE + 32'hC, 32'h2, 4'b0001);
    wr("gate1000", A_BASE + 32'h4, 32'd1000, 4'hF);
    wr("go1", A_BASE, 32'h1, 4'b0001);
    e0 = last_ack_edge;
    wait_ack_at(e0 + 1018);
    rd_reg("m1_busy", A_BASE + 32'hC, v);    chk("m1_busy", v, 32'b001);
    wait_ack_at(e0 + 1020);
    rd_reg("m1_done", A_BASE + 32'hC, v);    chk("m1_done", v, 32'b010);
    rd_reg("m1_cnt", A_BASE + 32'h8, v);     chk_rng("m1_cnt", v, 99, 101);

    // Locking and abort during MEASURE
    wr("clr2", A_BASE + 32'hC, 32'h2, 4'b0001);
    wr("go2", A_BASE, 32'h1, 4'b0001);
    e0 = last_ack_edge;
    wait_ack_at(e0 + 300);
    rd_reg("m2_busy", A_BASE + 32'hC, v);    chk("m2_busy", v, 32'b001);
    wr("go_again", A_BASE, 32'h1, 4'b0001);
    rd_reg("m2_busy2", A_BASE + 32'hC, v);   chk("m2_busy2", v, 32'b001);
    wr("sel_locked", A_BASE, 32'h0000_3000, 4'b0011);
    chk("ro_sel_locked", {28'd0, ro_sel_a}, 32'hA);
    wr("abort", A_BASE, 32'h4, 4'b0001);
    rd_reg("abort_stat", A_BASE + 32'hC, v); chk("abort_stat", v, 32'd0);
    rd_reg("abort_cnt", A_BASE + 32'h8, v);  chk_rng("abort_cnt", v, 99, 101);

    // Saturation on the 8-bit instance
    ro_half = 20;
    wr("b_gate", B_BASE + 32'h4, 32'd2000, 4'hF);
    wr("b_go", B_BASE, 32'h1, 4'b0001);
    e0 = last_ack_edge;
    wait_ack_at(e0 + 2020);
    rd_reg("b_stat", B_BASE + 32'hC, v);     chk("b_stat", v, 32'b110);
    rd_reg("b_cnt", B_BASE + 32'h8, v);      chk("b_cnt", v, 32'd255);
    wr("b_w1c", B_BASE + 32'hC, 32'h6, 4'b0001);
    rd_reg("b_clr", B_BASE + 32'hC, v);      chk("b_clr", v, 32'd0);

    // Reset mid-measurement, then a fresh measurement
    ro_half = 50;
    wr("go3", A_BASE, 32'h1, 4'b0001);
    e0 = last_ack_edge;
    wait_ack_at(e0 + 500);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", {22'd0, ro_sel_a, ro_en_a, ro_start_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_reg("r_stat", A_BASE + 32'hC, v);     chk("r_stat", v, 32'd0);
    rd_reg("r_cnt", A_BASE + 32'h8, v);      chk("r_cnt", v, 32'd0);
    rd_reg("r_gate", A_BASE + 32'h4, v);     chk("r_gate", v, 32'd1000);
    wr("go4", A_BASE, 32'h1, 4'b0001);
    e0 = last_ack_edge;
    wait_ack_at(e0 + 1020);
    rd_reg("m4_done", A_BASE + 32'hC, v);    chk("m4_done", v, 32'b010);
    rd_reg("m4_cnt", A_BASE + 32'h8, v);     chk_rng("m4_cnt", v, 99, 101);

    // Outside the decoded window
    begin
      int acks;
      bus(A_BASE + 32'h10, 1'b0, '0, 4'hF, v, acks);
      chk("no_ack", 32'(acks), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
